fft_frame_buffer: RTL and testbench
===================================

FFT_FRAME_BUFFER -- requirements
Module: fft_frame_buffer

Interface
- REQ-001: Parameter SAMPLE_W, default 18, sets the signed real-sample width; each complex word is 2*SAMPLE_W bits.
- REQ-002: Parameter CNT_W, default 8, sets the overrun counter width.
- REQ-003: clk  input  1  single clock, all state on rising edge.
- REQ-004: reset  input  1  asynchronous, active-high.
- REQ-005: sample_valid  input  1  sample_in is valid this cycle; no backpressure.
- REQ-006: sample_in  input  SAMPLE_W  signed audio sample.
- REQ-007: fft_done  input  1  completion flag from the 16-point FFT.
- REQ-008: in0..in15  output  2*SAMPLE_W each  frame words {real, imag}; in0 is the oldest sample.
- REQ-009: start  output  1  frame valid; FFT request.
- REQ-010: overrun_cnt  output  CNT_W  saturating count of dropped samples.
- REQ-011: frame_cnt  output  16  frames issued, wraps at 2^16.

Function
- REQ-012: The block SHALL hold a 16-entry sample shift register and a 5-bit fill count (0..16).
- REQ-013: An accepted sample SHALL shift in at the newest end, and the count SHALL increment.
- REQ-014: The state machine SHALL have two states, IDLE (start=0) and BUSY (start=1).
- REQ-015: Packing SHALL be in_k = {sample_k, SAMPLE_W'b0}, i.e. imaginary part zero and sample sign preserved.
- REQ-016: In IDLE, when the count reaches 16 (including the edge that accepts the 16th sample), the edge SHALL load in0..in15, move to BUSY and increment frame_cnt.
  - start is registered: it goes high the cycle after that edge.
- REQ-017: A load SHALL reset the count to 0, unless overlap is compiled in.
- REQ-018: fft_done SHALL be rising-edge detected via a registered copy.
  - A rise in BUSY SHALL return to IDLE, so start falls the following cycle.
  - A rise in IDLE SHALL be ignored.
- REQ-019: While BUSY, samples SHALL keep filling the shift register (double buffering); in0..in15 SHALL stay stable.
- REQ-020: While the count is 16 and no load occurs, an arriving sample SHALL be dropped and overrun_cnt SHALL increment, saturating at all-ones.
- REQ-021: In IDLE with count 16 and sample_valid high on the same edge:
  - the load SHALL capture the existing 16 samples;
  - the new sample SHALL become the first sample of the next fill.
- REQ-022: start SHALL be low for at least one cycle between consecutive frames.

Reset
- REQ-023: Reset SHALL asynchronously clear:
  - the state to IDLE and start to 0;
  - the count, the shift register and in0..in15 to 0;
  - overrun_cnt, frame_cnt and the fft_done edge register to 0.
- REQ-024: Reset mid-fill or mid-BUSY SHALL discard all partial data; the first frame after release needs 16 fresh samples.

Configuration
- REQ-025: When FFT_FRAME_OVERLAP_EN is defined:
  - a load SHALL set the count to 8, retaining the newest 8 samples (50% overlap);
  - each subsequent frame therefore needs 8 new samples;
  - the first frame after reset still needs 16.
- REQ-026: When FFT_FRAME_OVERLAP_EN is undefined, every frame SHALL consist of 16 new samples.

Structure
- REQ-027: Package fft_pkg SHALL hold:
  - FFT_N=16 and the default SAMPLE_W;
  - a complex-word typedef (real upper half, imag lower half);
  - the IDLE/BUSY state enum.
- REQ-028: The block SHALL be a single module with no sub-modules; the fft_done edge detector is inline.

Verification
- REQ-029: Feed samples 100×4, 200×4, 300×4, 400×4 (no overlap). Expect:
  - in0..in3={100,0}, in4..in7={200,0}, in8..in11={300,0}, in12..in15={400,0};
  - start high exactly one cycle after the 16th sample edge;
  - frame_cnt=1.
- REQ-030: Pulse fft_done in BUSY. Expect:
  - start low the next cycle;
  - with a second full frame already buffered, start high again one cycle later with the new frame.
- REQ-031: Send 33 samples with no fft_done. Expect:
  - frame 1 issued and samples 17..32 buffered;
  - sample 33 dropped and overrun_cnt=1;
  - saturation at 255 after 255 further drops.
- REQ-032: Assert reset after 10 samples. Expect:
  - start and the outputs at 0 immediately;
  - no frame after 6 more samples;
  - a frame after 16 post-reset samples.
- REQ-033: With FFT_FRAME_OVERLAP_EN defined, feed samples 1..24 and pulse fft_done after frame 1. Expect:
  - frame 2 has in0..in7 = samples 9..16 and in8..in15 = samples 17..24.
- REQ-034: Feed sample_in=-5 (SAMPLE_W=18). Expect that word's real part = 18'h3FFFB and imaginary part = 0.

Source files
------------

// File: rtl/fft_pkg.sv
// ============================================================================
// fft_pkg : shared constants and types for the 16-point FFT frame buffer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package fft_pkg;

  localparam int FFT_N        = 16;
  localparam int SAMPLE_W_DEF = 18;

  // Complex FFT input word: real part in the upper half, imaginary in the lower.
  typedef struct packed {
    logic signed [SAMPLE_W_DEF-1:0] re;
    logic signed [SAMPLE_W_DEF-1:0] im;
  } cplx_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fft_frame_buffer.sv
// ============================================================================
// fft_frame_buffer : collects 16 real samples into a complex frame for the FFT,
// double-buffered, with overrun counting. Optional 50% overlap: FFT_FRAME_OVERLAP_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       fft_done,
  output logic [2*SAMPLE_W-1:0]      in0,
  output logic [2*SAMPLE_W-1:0]      in1,
  output logic [2*SAMPLE_W-1:0]      in2,
  output logic [2*SAMPLE_W-1:0]      in3,
  output logic [2*SAMPLE_W-1:0]      in4,
  output logic [2*SAMPLE_W-1:0]      in5,
  output logic [2*SAMPLE_W-1:0]      in6,
  output logic [2*SAMPLE_W-1:0]      in7,
  output logic [2*SAMPLE_W-1:0]      in8,
  output logic [2*SAMPLE_W-1:0]      in9,
  output logic [2*SAMPLE_W-1:0]      in10,
  output logic [2*SAMPLE_W-1:0]      in11,
  output logic [2*SAMPLE_W-1:0]      in12,
  output logic [2*SAMPLE_W-1:0]      in13,
  output logic [2*SAMPLE_W-1:0]      in14,
  output logic [2*SAMPLE_W-1:0]      in15,
  output logic                       start,
  output logic [CNT_W-1:0]           overrun_cnt,
  output logic [15:0]                frame_cnt
);

`ifdef FFT_FRAME_OVERLAP_EN
  localparam logic [4:0] c_RELOAD = 5'd8;
`else
  localparam logic [4:0] c_RELOAD = 5'd0;
`endif
  localparam logic [4:0] c_FULL = 5'(FFT_N);

  state_t                r_state;
  logic                  r_start;
  logic                  r_done_d;
  logic [4:0]            r_count;
  logic [SAMPLE_W-1:0]   r_shift [FFT_N];
  logic [2*SAMPLE_W-1:0] r_frame [FFT_N];
  logic [CNT_W-1:0]      r_overrun;
  logic [15:0]           r_frame_cnt;

  logic                  w_rise;
  logic                  w_full;
  logic                  w_fill_last;
  logic                  w_load;
  logic                  w_shift;
  logic                  w_drop;
  logic [4:0]            w_count_nxt;
  logic [SAMPLE_W-1:0]   w_shifted [FFT_N];

  assign w_rise      = fft_done & ~r_done_d;
  assign w_full      = (r_count == c_FULL);
  assign w_fill_last = sample_valid && (r_count == c_FULL - 5'd1);
  assign w_load      = (r_state == ST_IDLE) && (w_full || w_fill_last);
  // A full buffer only accepts a sample on the edge that empties it into the frame.
  assign w_shift     = sample_valid && (!w_full || w_load);
  assign w_drop      = sample_valid && w_full && !w_load;

  always_comb begin
    for (int k = 0; k < FFT_N - 1; k++) begin
      w_shifted[k] = r_shift[k+1];
    end
    w_shifted[FFT_N-1] = sample_in;
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_load) begin
      w_count_nxt = w_full ? (c_RELOAD + {4'd0, sample_valid}) : c_RELOAD;
    end else if (w_shift) begin
      w_count_nxt = r_count + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_start     <= 1'b0;
      r_done_d    <= 1'b0;
      r_count     <= '0;
      r_overrun   <= '0;
      r_frame_cnt <= '0;
      for (int k = 0; k < FFT_N; k++) begin
        r_shift[k] <= '0;
        r_frame[k] <= '0;
      end
    end else begin
      r_done_d <= fft_done;
      r_count  <= w_count_nxt;
      if (w_shift) begin
        for (int k = 0; k < FFT_N; k++) begin
          r_shift[k] <= w_shifted[k];
        end
      end
      if (w_drop && (r_overrun != '1)) begin
        r_overrun <= r_overrun + CNT_W'(1);
      end
      // When the 16th sample arrives on the load edge, capture the post-shift view.
      if (w_load) begin
        for (int k = 0; k < FFT_N; k++) begin
          r_frame[k] <= {(w_full ? r_shift[k] : w_shifted[k]), {SAMPLE_W{1'b0}}};
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state     <= ST_BUSY;
            r_start     <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end
        end
        ST_BUSY: begin
          if (w_rise) begin
            r_state <= ST_IDLE;
            r_start <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_start <= 1'b0;
        end
      endcase
    end
  end

  assign in0         = r_frame[0];
  assign in1         = r_frame[1];
  assign in2         = r_frame[2];
  assign in3         = r_frame[3];
  assign in4         = r_frame[4];
  assign in5         = r_frame[5];
  assign in6         = r_frame[6];
  assign in7         = r_frame[7];
  assign in8         = r_frame[8];
  assign in9         = r_frame[9];
  assign in10        = r_frame[10];
  assign in11        = r_frame[11];
  assign in12        = r_frame[12];
  assign in13        = r_frame[13];
  assign in14        = r_frame[14];
  assign in15        = r_frame[15];
  assign start       = r_start;
  assign overrun_cnt = r_overrun;
  assign frame_cnt   = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_buffer.sv
// ============================================================================
// tb_fft_frame_buffer : scoreboard bench for fft_frame_buffer with a queue-based
// reference model of the sample stream. Honours FFT_FRAME_OVERLAP_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_fft_frame_buffer;
  import fft_pkg::*;

  localparam int SW = 18;
  localparam int CW = 8;
  localparam int WW = 2 * SW;
  localparam int FW = FFT_N * WW;
`ifdef FFT_FRAME_OVERLAP_EN
  localparam int c_OV_AFTER_33 = 9;
`else
  localparam int c_OV_AFTER_33 = 1;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 sample_valid;
  logic signed [SW-1:0] sample_in;
  logic                 fft_done;
  logic [WW-1:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic [WW-1:0] in8, in9, in10, in11, in12, in13, in14, in15;
  logic                 start;
  logic [CW-1:0]        overrun_cnt;
  logic [15:0]          frame_cnt;
  logic [FW-1:0]        w_out;

  always #5 clk = ~clk;

  fft_frame_buffer #(.SAMPLE_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .fft_done(fft_done),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5), .in6(in6), .in7(in7),
    .in8(in8), .in9(in9), .in10(in10), .in11(in11), .in12(in12), .in13(in13), .in14(in14),
    .in15(in15), .start(start), .overrun_cnt(overrun_cnt), .frame_cnt(frame_cnt)
  );

  assign w_out = {in15, in14, in13, in12, in11, in10, in9, in8, in7, in6, in5, in4, in3, in2, in1, in0};

  // Reference model: the accepted-sample stream as a queue plus a busy flag.
  logic signed [SW-1:0] m_buf[$];
  bit                   m_busy;
  bit                   m_prev_done;
  int                   m_ov;
  int                   m_fc;
  logic [FW-1:0]        exp_q[$];
  logic [FW-1:0]        cur_exp;
  logic [FW-1:0]        f_exp;
  bit                   prev_start;
  int                   n_tests = 0;
  int                   n_fail  = 0;
  cplx_t                c_word;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit v, input logic signed [SW-1:0] s, input bit d);
    bit            rise;
    int            n;
    logic [FW-1:0] f;
    rise        = d && !m_prev_done;
    m_prev_done = d;
    n           = m_buf.size();
    if (!m_busy && (n == 16 || (n == 15 && v))) begin
      if (n == 15) m_buf.push_back(s);
      for (int k = 0; k < 16; k++) f[k*WW +: WW] = {m_buf[k], {SW{1'b0}}};
      exp_q.push_back(f);
      m_fc   = (m_fc + 1) % 65536;
      m_busy = 1'b1;
`ifdef FFT_FRAME_OVERLAP_EN
      repeat (8) void'(m_buf.pop_front());
`else
      m_buf.delete();
`endif
      if (n == 16 && v) m_buf.push_back(s);
    end else begin
      if (v) begin
        if (m_buf.size() < 16) m_buf.push_back(s);
        else if (m_ov < 255) m_ov++;
      end
      if (m_busy && rise) m_busy = 1'b0;
    end
  endtask

  task automatic cycle(input bit v, input logic signed [SW-1:0] s, input bit d);
    @(negedge clk);
    sample_valid = v;
    sample_in    = s;
    fft_done     = d;
    model_step(v, s, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    sample_valid = 1'b0;
    fft_done     = 1'b0;
    sample_in    = '0;
    m_buf.delete();
    m_busy      = 1'b0;
    m_prev_done = 1'b0;
    m_ov        = 0;
    m_fc        = 0;
    prev_start  = 1'b0;
    cur_exp     = '0;
    #1;
    check("rst_frame", w_out, '0);
    check("rst_start", start, 0);
    check("rst_overrun", overrun_cnt, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: per-cycle control checks, frame pop on every start rise.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      check("start", start, m_busy);
      check("overrun_cnt", overrun_cnt, m_ov[CW-1:0]);
      check("frame_cnt", frame_cnt, m_fc[15:0]);
      if (start && !prev_start) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL frame_unexpected: got frame %0h expected none", w_out);
        end else begin
          cur_exp = exp_q.pop_front();
          check("frame", w_out, cur_exp);
        end
      end else if (start) begin
        check("frame_stable", w_out, cur_exp);
      end
      prev_start = start;
    end
  end

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    fft_done     = 1'b0;
    do_reset();

    // Step pattern 100/200/300/400, four each.
    for (int g = 0; g < 4; g++)
      for (int j = 0; j < 4; j++) cycle(1'b1, SW'((g + 1) * 100), 1'b0);
    for (int k = 0; k < 16; k++) f_exp[k*WW +: WW] = {SW'((k / 4 + 1) * 100), {SW{1'b0}}};
    @(posedge clk); #1;
    check("step_frame", w_out, f_exp);
    check("step_start", start, 1);
    check("step_frame_cnt", frame_cnt, 1);

    // Second frame fills while busy; first sample of it is negative.
    cycle(1'b1, -SW'(5), 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b1, SW'($urandom), 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    @(posedge clk); #1;
    check("done_start_low", start, 0);
    cycle(1'b1, SW'($urandom), 1'b1);
    c_word.re = -18'sd5;
    c_word.im = '0;
    @(posedge clk); #1;
    check("neg5_word", in0, c_word);
    check("reload_start", start, 1);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);

    // Overrun and saturation.
    do_reset();
    for (int i = 1; i <= 33; i++) cycle(1'b1, SW'(i), 1'b0);
    @(posedge clk); #1;
    check("overrun_first", overrun_cnt, c_OV_AFTER_33);
    for (int i = 0; i < 260; i++) cycle(1'b1, SW'($urandom), 1'b0);
    @(posedge clk); #1;
    check("overrun_sat", overrun_cnt, 255);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    @(posedge clk); #1;
    check("frame2_start", start, 1);
`ifndef FFT_FRAME_OVERLAP_EN
    check("frame2_in0", in0, {SW'(17), {SW{1'b0}}});
    check("frame2_in15", in15, {SW'(32), {SW{1'b0}}});
`endif

    // Reset mid-fill discards partial data.
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b1, SW'($urandom), 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, SW'($urandom), 1'b0);
    cycle(1'b0, '0, 1'b0);
    @(posedge clk); #1;
    check("partial_no_frame", start, 0);
    for (int i = 0; i < 10; i++) cycle(1'b1, SW'($urandom), 1'b0);
    @(posedge clk); #1;
    check("post_reset_frame", start, 1);

`ifdef FFT_FRAME_OVERLAP_EN
    do_reset();
    for (int i = 1; i <= 24; i++) cycle(1'b1, SW'(i), 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    for (int k = 0; k < 16; k++) f_exp[k*WW +: WW] = {SW'(k + 9), {SW{1'b0}}};
    @(posedge clk); #1;
    check("overlap_frame2", w_out, f_exp);
`endif

    // Randomised traffic with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cycle($urandom_range(0, 9) < 7, SW'($urandom), $urandom_range(0, 11) == 0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0);
    @(posedge clk); #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
